// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage pipeline (PC enable, b1..b4 enable/flush).
// Latency: all control outputs are combinational from state and inputs; state/counters/mem_err are registered.
// Backpressure: a busy data memory freezes the whole pipe (MWAIT) until mem_ready or the timeout releases it.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   id_rs, id_rt, id_uses_rt         source registers of the instruction in ID
//   ex_memtoreg, ex_AW               load flag and destination register held in ID/EX
//   mem_pcsrc, mem_zero              branch and its condition held in EX/MEM
//   mem_er, mem_ew, mem_ready        data-memory request and completion
//   pc_en, b1_en..b4_en              PC and buffer load enables
//   b1_flush..b3_flush               buffer clears (override the enables)
//   take_branch                      select branch target into the PC
//   mem_err                          sticky memory-timeout flag
//   state                            RUN=0, MWAIT=1, BFLUSH=2
// Optional macro PIPE_CTRL_PERF_EN adds saturating stall_cnt, flush_cnt, memwait_cnt outputs.

module pipe_ctrl #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memtoreg,
  input  logic [4:0]  ex_AW,
  input  logic        mem_pcsrc,
  input  logic        mem_zero,
  input  logic        mem_er,
  input  logic        mem_ew,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        b1_en,
  output logic        b2_en,
  output logic        b3_en,
  output logic        b4_en,
  output logic        b1_flush,
  output logic        b2_flush,
  output logic        b3_flush,
  output logic        take_branch,
  output logic        mem_err,
  output logic [1:0]  state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] memwait_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MWAIT  = 2'd1,
    BFLUSH = 2'd2
  } state_t;

  // One counter serves both the memory timeout and the flush count.
  localparam int CNT_MAX = (MEM_TIMEOUT > 7) ? MEM_TIMEOUT : 7;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] FL_VAL = CW'(FLUSH_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_err_q, mem_err_d;

  logic mem_busy, br, lu;
  logic run_mode, busy_eff;

  assign mem_busy = (mem_er | mem_ew) & ~mem_ready;
  assign br       = mem_pcsrc & mem_zero;
  assign lu       = ex_memtoreg & (ex_AW != 5'd0) &
                    ((ex_AW == id_rs) | (id_uses_rt & (ex_AW == id_rt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_err_d   = mem_err_q;
    pc_en       = 1'b0;
    b1_en       = 1'b0;
    b2_en       = 1'b0;
    b3_en       = 1'b0;
    b4_en       = 1'b0;
    b1_flush    = 1'b0;
    b2_flush    = 1'b0;
    b3_flush    = 1'b0;
    take_branch = 1'b0;
    run_mode    = 1'b0;
    busy_eff    = mem_busy;

    case (state_q)
      RUN: run_mode = 1'b1;
      MWAIT: begin
        if (mem_busy && (cnt_q != TO_VAL)) begin
          cnt_d = cnt_q + ONE;       // still frozen
        end else begin
          // Completion or timeout: this cycle acts as RUN with memory idle,
          // so a branch or load-use held behind the access is serviced now.
          run_mode = 1'b1;
          busy_eff = 1'b0;
          if (mem_busy) mem_err_d = 1'b1;
        end
      end
      BFLUSH: begin
        if (mem_busy) begin
          // Remaining flush count is dropped; the frozen pipe holds no wrong-path fetch
          // beyond what b1 already captured and will be flushed... only via MWAIT rules.
          state_d = MWAIT;
          cnt_d   = ONE;
        end else begin
          pc_en    = 1'b1;
          b1_en    = 1'b1;
          b2_en    = 1'b1;
          b3_en    = 1'b1;
          b4_en    = 1'b1;
          b1_flush = 1'b1;
          if (cnt_q == FL_VAL) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    if (run_mode) begin
      if (busy_eff) begin
        state_d = MWAIT;
        cnt_d   = ONE;
      end else if (br) begin
        // Branch wins over load-use: the dependent ID instruction is flushed anyway.
        take_branch = 1'b1;
        pc_en       = 1'b1;
        b1_en       = 1'b1;
        b2_en       = 1'b1;
        b3_en       = 1'b1;
        b4_en       = 1'b1;
        b1_flush    = 1'b1;
        b2_flush    = 1'b1;
        b3_flush    = 1'b1;
        if (FLUSH_CYCLES > 0) begin
          state_d = BFLUSH;
          cnt_d   = ONE;
        end else begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end else if (lu) begin
        // Hold PC and IF/ID, inject one bubble into ID/EX.
        b2_en    = 1'b1;
        b2_flush = 1'b1;
        b3_en    = 1'b1;
        b4_en    = 1'b1;
        state_d  = RUN;
        cnt_d    = '0;
      end else begin
        pc_en   = 1'b1;
        b1_en   = 1'b1;
        b2_en   = 1'b1;
        b3_en   = 1'b1;
        b4_en   = 1'b1;
        state_d = RUN;
        cnt_d   = '0;
      end
    end

    // While in reset the buffers are held clear regardless of state.
    if (!rst_n) begin
      pc_en       = 1'b0;
      b1_en       = 1'b0;
      b2_en       = 1'b0;
      b3_en       = 1'b0;
      b4_en       = 1'b0;
      b1_flush    = 1'b1;
      b2_flush    = 1'b1;
      b3_flush    = 1'b1;
      take_branch = 1'b0;
    end
  end

  assign mem_err = mem_err_q;
  assign state   = state_q;

`ifdef PIPE_CTRL_PERF_EN
  // A load-use bubble is the only case flushing b2 without b1.
  logic stall_ev;
  assign stall_ev = b2_flush & ~b1_flush & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      memwait_cnt <= '0;
    end else begin
      if (stall_ev && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if (take_branch && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 32'd1;
      if ((state_q == MWAIT) && (memwait_cnt != '1))
        memwait_cnt <= memwait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed cycles, expected control vectors queued at drive time
// and compared (under a care mask) at the following negedge.
// Default parameters: MEM_TIMEOUT=16, FLUSH_CYCLES=1.

module tb_pipe_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_AW;
  logic       id_uses_rt, ex_memtoreg, mem_pcsrc, mem_zero, mem_er, mem_ew, mem_ready;
  logic       pc_en, b1_en, b2_en, b3_en, b4_en, b1_flush, b2_flush, b3_flush;
  logic       take_branch, mem_err;
  logic [1:0] state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, memwait_cnt;
`endif

  pipe_ctrl #(.MEM_TIMEOUT(16), .FLUSH_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memtoreg(ex_memtoreg), .ex_AW(ex_AW),
    .mem_pcsrc(mem_pcsrc), .mem_zero(mem_zero),
    .mem_er(mem_er), .mem_ew(mem_ew), .mem_ready(mem_ready),
    .pc_en(pc_en), .b1_en(b1_en), .b2_en(b2_en), .b3_en(b3_en), .b4_en(b4_en),
    .b1_flush(b1_flush), .b2_flush(b2_flush), .b3_flush(b3_flush),
    .take_branch(take_branch), .mem_err(mem_err), .state(state)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upper 9 bits: {pc_en, b1_en, b2_en, b3_en, b4_en, b1_flush, b2_flush, b3_flush, take_branch}
  localparam logic [8:0] K_NORM = 9'b111110000;
  localparam logic [8:0] K_RST  = 9'b000001110;
  localparam logic [8:0] K_FRZ  = 9'b000000000;
  localparam logic [8:0] K_LU   = 9'b000110100;
  localparam logic [8:0] K_BR   = 9'b100011111;
  localparam logic [8:0] K_BF   = 9'b101111000;
  localparam logic [8:0] M_ALL  = 9'b111111111;
  localparam logic [8:0] M_LU   = 9'b110111111;  // b2_en free (b2 is flushed)
  localparam logic [8:0] M_BR   = 9'b100011111;  // b1..b3 enables free (flushed)
  localparam logic [8:0] M_BF   = 9'b101111111;  // b1_en free (b1 is flushed)

  int errors = 0;
  int checks = 0;

  string       tag_q[$];
  logic [11:0] exp_q[$];
  logic [11:0] msk_q[$];

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (pc b1e b2e b3e b4e f1 f2 f3 tb err st)", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_memtoreg = 1'b0; ex_AW = 5'd0;
    mem_pcsrc = 1'b0; mem_zero = 1'b0;
    mem_er = 1'b0; mem_ew = 1'b0; mem_ready = 1'b0;
  endtask

  // Queue the expectation for the inputs just driven, compare at negedge, advance to posedge+1.
  task automatic cyc(input string tag, input logic [8:0] k, input logic [8:0] m,
                     input logic err, input logic [1:0] st);
    logic [11:0] obs, e, mk;
    tag_q.push_back(tag);
    exp_q.push_back({k, err, st});
    msk_q.push_back({m, 3'b111});
    @(negedge clk);
    obs = {pc_en, b1_en, b2_en, b3_en, b4_en, b1_flush, b2_flush, b3_flush,
           take_branch, mem_err, state};
    e  = exp_q.pop_front();
    mk = msk_q.pop_front();
    check(tag_q.pop_front(), obs & mk, e & mk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    for (int i = 0; i < 3; i++) cyc("reset", K_RST, M_ALL, 1'b0, 2'd0);
    rst_n = 1'b1;
    cyc("post_reset", K_NORM, M_ALL, 1'b0, 2'd0);
    cyc("idle", K_NORM, M_ALL, 1'b0, 2'd0);

    // Load-use on rs
    ex_memtoreg = 1'b1; ex_AW = 5'd5; id_rs = 5'd5;
    cyc("lu_rs", K_LU, M_LU, 1'b0, 2'd0);
    idle();
    cyc("lu_rs_after", K_NORM, M_ALL, 1'b0, 2'd0);

    // Load-use on rt, then same registers without rt use
    ex_memtoreg = 1'b1; ex_AW = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; id_rs = 5'd3;
    cyc("lu_rt", K_LU, M_LU, 1'b0, 2'd0);
    id_uses_rt = 1'b0;
    cyc("no_lu_rt_unused", K_NORM, M_ALL, 1'b0, 2'd0);

    // Destination r0 never stalls
    idle(); ex_memtoreg = 1'b1; ex_AW = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    cyc("lu_r0", K_NORM, M_ALL, 1'b0, 2'd0);

    // Branch not taken
    idle(); mem_pcsrc = 1'b1; mem_zero = 1'b0;
    cyc("br_not_taken", K_NORM, M_ALL, 1'b0, 2'd0);

    // Taken branch
    mem_zero = 1'b1;
    cyc("br", K_BR, M_BR, 1'b0, 2'd0);
    idle();
    cyc("br_bflush", K_BF, M_BF, 1'b0, 2'd2);
    cyc("br_back", K_NORM, M_ALL, 1'b0, 2'd0);

    // Branch and load-use together: branch wins
    mem_pcsrc = 1'b1; mem_zero = 1'b1; ex_memtoreg = 1'b1; ex_AW = 5'd5; id_rs = 5'd5;
    cyc("br_lu", K_BR, M_BR, 1'b0, 2'd0);
    idle();
    cyc("br_lu_bflush", K_BF, M_BF, 1'b0, 2'd2);
    cyc("br_lu_back", K_NORM, M_ALL, 1'b0, 2'd0);

    // Memory wait, 4 busy cycles
    mem_er = 1'b1; mem_ready = 1'b0;
    cyc("mw_enter", K_FRZ, M_ALL, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) cyc("mw_wait", K_FRZ, M_ALL, 1'b0, 2'd1);
    mem_ready = 1'b1;
    cyc("mw_release", K_NORM, M_ALL, 1'b0, 2'd1);
    idle();
    cyc("mw_back", K_NORM, M_ALL, 1'b0, 2'd0);

    // Busy memory with a held branch: freeze, then branch when ready rises
    mem_ew = 1'b1; mem_pcsrc = 1'b1; mem_zero = 1'b1;
    cyc("mb_br_enter", K_FRZ, M_ALL, 1'b0, 2'd0);
    for (int i = 0; i < 2; i++) cyc("mb_br_wait", K_FRZ, M_ALL, 1'b0, 2'd1);
    mem_ready = 1'b1;
    cyc("mb_br_take", K_BR, M_BR, 1'b0, 2'd1);
    idle();
    cyc("mb_br_bflush", K_BF, M_BF, 1'b0, 2'd2);
    cyc("mb_br_back", K_NORM, M_ALL, 1'b0, 2'd0);

    // New memory wait during BFLUSH takes priority
    mem_pcsrc = 1'b1; mem_zero = 1'b1;
    cyc("bf_mb_br", K_BR, M_BR, 1'b0, 2'd0);
    idle(); mem_er = 1'b1;
    cyc("bf_mb_freeze", K_FRZ, M_ALL, 1'b0, 2'd2);
    cyc("bf_mb_wait", K_FRZ, M_ALL, 1'b0, 2'd1);
    mem_ready = 1'b1;
    cyc("bf_mb_release", K_NORM, M_ALL, 1'b0, 2'd1);
    idle();
    cyc("bf_mb_back", K_NORM, M_ALL, 1'b0, 2'd0);

    // Load-use held behind a memory wait is serviced on release
    mem_er = 1'b1; ex_memtoreg = 1'b1; ex_AW = 5'd9; id_rs = 5'd9;
    cyc("mb_lu_enter", K_FRZ, M_ALL, 1'b0, 2'd0);
    cyc("mb_lu_wait", K_FRZ, M_ALL, 1'b0, 2'd1);
    mem_ready = 1'b1;
    cyc("mb_lu_stall", K_LU, M_LU, 1'b0, 2'd1);
    idle();
    cyc("mb_lu_back", K_NORM, M_ALL, 1'b0, 2'd0);

    // Timeout: 1 RUN freeze + 15 MWAIT freezes, forced release on the 16th MWAIT cycle
    mem_ew = 1'b1; mem_ready = 1'b0;
    cyc("to_enter", K_FRZ, M_ALL, 1'b0, 2'd0);
    for (int i = 0; i < 15; i++) cyc("to_wait", K_FRZ, M_ALL, 1'b0, 2'd1);
    cyc("to_release", K_NORM, M_ALL, 1'b0, 2'd1);
    idle();
    cyc("to_err_set", K_NORM, M_ALL, 1'b1, 2'd0);
    cyc("to_err_sticky", K_NORM, M_ALL, 1'b1, 2'd0);
    ex_memtoreg = 1'b1; ex_AW = 5'd4; id_rs = 5'd4;
    cyc("to_err_lu", K_LU, M_LU, 1'b1, 2'd0);
    idle();
    rst_n = 1'b0;
    cyc("to_err_reset", K_RST, M_ALL, 1'b0, 2'd0);
    rst_n = 1'b1;
    cyc("to_err_cleared", K_NORM, M_ALL, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
